// File: rtl/caja_registradora.sv
// Register stage: accumulates drink values into a saturating running total, counts orders,
// and holds a ticket on a valid/ready port until the consumer takes it.
module caja_registradora #(
  parameter int DATA_W      = 8,
  parameter int TOTAL_W     = 16,
  parameter int MAX_PEDIDOS = 4,
  localparam int CNT_W      = $clog2(MAX_PEDIDOS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  bebida,
  input  logic               bebida_valid,
  output logic               bebida_ready,
  input  logic               cerrar,
  output logic [TOTAL_W-1:0] ticket_total,
  output logic [CNT_W-1:0]   ticket_pedidos,
  output logic               ticket_valid,
  input  logic               ticket_ready,
  output logic               saturado
);

  typedef enum logic [0:0] {
    ACUMULA = 1'b0,
    TICKET  = 1'b1
  } estado_e;

  estado_e            state_q, state_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               saturado_q, saturado_d;

  logic               accept_s;
  logic [TOTAL_W:0]   sum_s;
  logic [CNT_W-1:0]   count_inc_s;

  // One extra bit on the sum exposes the carry used as the clip flag.
  function automatic logic [TOTAL_W:0] suma_ext(input logic [TOTAL_W-1:0] a,
                                                input logic [DATA_W-1:0]  b);
    suma_ext = {1'b0, a} + {{(TOTAL_W + 1 - DATA_W){1'b0}}, b};
  endfunction

  // Next-state, accumulation and clear logic
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    count_d     = count_q;
    saturado_d  = saturado_q;
    accept_s    = 1'b0;
    sum_s       = suma_ext(total_q, bebida);
    count_inc_s = count_q + CNT_W'(1);

    case (state_q)
      ACUMULA: begin
        accept_s = bebida_valid;
        if (accept_s) begin
          if (sum_s[TOTAL_W]) begin
            total_d    = {TOTAL_W{1'b1}};
            saturado_d = 1'b1;
          end else begin
            total_d = sum_s[TOTAL_W-1:0];
          end
          count_d = count_inc_s;
          if ((count_inc_s == CNT_W'(MAX_PEDIDOS)) || cerrar) begin
            state_d = TICKET;
          end else begin
            state_d = ACUMULA;
          end
        end else if (cerrar && (count_q != {CNT_W{1'b0}})) begin
          // An early close never produces an empty ticket.
          state_d = TICKET;
        end else begin
          state_d = ACUMULA;
        end
      end
      TICKET: begin
        if (ticket_ready) begin
          total_d    = {TOTAL_W{1'b0}};
          count_d    = {CNT_W{1'b0}};
          saturado_d = 1'b0;
          state_d    = ACUMULA;
        end else begin
          state_d = TICKET;
        end
      end
      default: begin
        state_d = ACUMULA;
      end
    endcase
  end

  // State and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACUMULA;
      total_q    <= {TOTAL_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      saturado_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      count_q    <= count_d;
      saturado_q <= saturado_d;
    end
  end

  assign bebida_ready   = (state_q == ACUMULA);
  assign ticket_valid   = (state_q == TICKET);
  assign ticket_total   = total_q;
  assign ticket_pedidos = count_q;
  assign saturado       = saturado_q;

endmodule

// File: tb/tb_caja_registradora.sv
// Cycle-driven bench for caja_registradora: a reference model pushes expected tickets into a
// scoreboard when stimulus closes them, and they are popped and compared when the ticket is taken.
module tb_caja_registradora;

  localparam int DW   = 8;
  localparam int TW   = 9;
  localparam int MAXP = 4;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] bebida = '0;
  logic          bebida_valid = 1'b0;
  logic          bebida_ready;
  logic          cerrar = 1'b0;
  logic [TW-1:0] ticket_total;
  logic [CW-1:0] ticket_pedidos;
  logic          ticket_valid;
  logic          ticket_ready = 1'b0;
  logic          saturado;

  typedef struct {
    int total;
    int ped;
    int sat;
  } tkt_t;

  tkt_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_total, m_count, m_sat;
  bit   m_tkt;

  caja_registradora #(.DATA_W(DW), .TOTAL_W(TW), .MAX_PEDIDOS(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .bebida(bebida), .bebida_valid(bebida_valid),
    .bebida_ready(bebida_ready), .cerrar(cerrar), .ticket_total(ticket_total),
    .ticket_pedidos(ticket_pedidos), .ticket_valid(ticket_valid),
    .ticket_ready(ticket_ready), .saturado(saturado)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_total = 0;
    m_count = 0;
    m_sat   = 0;
    m_tkt   = 1'b0;
    sb_q.delete();
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance the model one clock.
  task automatic cycle(input bit v, input int d, input bit c, input bit tr);
    tkt_t t;
    int   sum;
    bit   go;
    check_eq("bebida_ready", 32'(bebida_ready), 32'(!m_tkt));
    check_eq("ticket_valid", 32'(ticket_valid), 32'(m_tkt));
    check_eq("total", 32'(ticket_total), 32'(m_total));
    check_eq("pedidos", 32'(ticket_pedidos), 32'(m_count));
    check_eq("saturado", 32'(saturado), 32'(m_sat));
    if (m_tkt) begin
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard: ticket expected but queue empty");
      end else begin
        t = sb_q[0];
        check_eq("sb_total", 32'(ticket_total), 32'(t.total));
        check_eq("sb_pedidos", 32'(ticket_pedidos), 32'(t.ped));
        check_eq("sb_saturado", 32'(saturado), 32'(t.sat));
        if (tr) void'(sb_q.pop_front());
      end
    end

    bebida_valid = v;
    bebida       = d[DW-1:0];
    cerrar       = c;
    ticket_ready = tr;

    go = 1'b0;
    if (m_tkt) begin
      if (tr) begin
        m_tkt   = 1'b0;
        m_total = 0;
        m_count = 0;
        m_sat   = 0;
      end
    end else begin
      if (v) begin
        sum = m_total + (d & 255);
        if (sum > TMAX) begin
          m_total = TMAX;
          m_sat   = 1;
        end else begin
          m_total = sum;
        end
        m_count++;
        go = (m_count == MAXP) || c;
      end else begin
        go = c && (m_count != 0);
      end
      if (go) begin
        m_tkt   = 1'b1;
        t.total = m_total;
        t.ped   = m_count;
        t.sat   = m_sat;
        sb_q.push_back(t);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    bebida_valid = 1'b0;
    cerrar       = 1'b0;
    ticket_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ticket_valid", 32'(ticket_valid), 32'd0);
    check_eq("rst_total", 32'(ticket_total), 32'd0);
    check_eq("rst_pedidos", 32'(ticket_pedidos), 32'd0);
    check_eq("rst_saturado", 32'(saturado), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: four back-to-back beats close the ticket automatically
    cycle(1'b1, 17, 1'b0, 1'b0);
    cycle(1'b1, 165, 1'b0, 1'b0);
    cycle(1'b1, 99, 1'b0, 1'b0);
    cycle(1'b1, 116, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);

    // 2: early close with no beat present
    cycle(1'b1, 182, 1'b0, 1'b0);
    cycle(1'b1, 116, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);

    // 3: close on empty ignored; close with a beat includes it
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 50, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);

    // 4: saturation at the 9-bit ceiling
    cycle(1'b1, 255, 1'b0, 1'b0);
    cycle(1'b1, 255, 1'b0, 1'b0);
    cycle(1'b1, 255, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);

    // 5: ticket held against a pending beat, then the beat enters after the bubble
    cycle(1'b1, 1, 1'b0, 1'b0);
    cycle(1'b1, 2, 1'b0, 1'b0);
    cycle(1'b1, 3, 1'b0, 1'b0);
    cycle(1'b1, 4, 1'b0, 1'b0);
    repeat (10) cycle(1'b1, 77, 1'b0, 1'b0);
    cycle(1'b1, 77, 1'b0, 1'b1);
    cycle(1'b1, 77, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);

    // 6: asynchronous reset mid-accumulation and during a held ticket
    cycle(1'b1, 10, 1'b0, 1'b0);
    cycle(1'b1, 20, 1'b0, 1'b0);
    async_reset();
    cycle(1'b1, 5, 1'b0, 1'b0);
    cycle(1'b1, 6, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    async_reset();
    cycle(1'b1, 9, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
